// File: rtl/mul_acc_buf.sv
// Group accumulator behind the shift-add multiplier: sums N products with
// saturation and parks each finished group in a one-entry valid/ready output register.
module mul_acc_buf #(
    parameter int PW = 16,
    parameter int AW = 20,
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          p_valid,
    input  logic [PW-1:0] p,
    output logic          p_ready,
    output logic          p_drop,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] acc_out,
    output logic          ovf_out,
    output logic [CW-1:0] grp_cnt
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] acc_reg, acc_next;
    logic [AW-1:0] acc_out_reg, acc_out_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          ovf_reg, ovf_next;
    logic          ovf_out_reg, ovf_out_next;
    logic          out_valid_reg, out_valid_next;
    logic          p_drop_reg, p_drop_next;

    logic          slot_free;
    logic          sat;
    logic          is_final;
    logic [AW:0]   sum_wide;
    logic [AW-1:0] sum_sat;

    assign slot_free = !out_valid_reg || out_ready;
    assign sum_wide  = {1'b0, acc_reg} + {{(AW + 1 - PW){1'b0}}, p};
    assign sat       = sum_wide[AW];
    assign sum_sat   = sat ? {AW{1'b1}} : sum_wide[AW-1:0];
    assign is_final  = (cnt_reg == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            acc_out_reg   <= '0;
            ovf_out_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            p_drop_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            ovf_reg       <= ovf_next;
            acc_out_reg   <= acc_out_next;
            ovf_out_reg   <= ovf_out_next;
            out_valid_reg <= out_valid_next;
            p_drop_reg    <= p_drop_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        ovf_next       = ovf_reg;
        acc_out_next   = acc_out_reg;
        ovf_out_next   = ovf_out_reg;
        out_valid_next = out_valid_reg && !out_ready;
        // Any product arriving while parked is lost, even if clr also discards the group.
        p_drop_next    = p_valid && (state_reg == HOLD);

        if (clr) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE, ACC: begin
                    if (p_valid) begin
                        if (!is_final) begin
                            acc_next   = sum_sat;
                            ovf_next   = ovf_reg | sat;
                            cnt_next   = cnt_reg + 1'b1;
                            state_next = ACC;
                        end else if (slot_free) begin
                            acc_out_next   = sum_sat;
                            ovf_out_next   = ovf_reg | sat;
                            out_valid_next = 1'b1;
                            acc_next       = '0;
                            cnt_next       = '0;
                            ovf_next       = 1'b0;
                            state_next     = IDLE;
                        end else begin
                            // Final product stays parked; cnt keeps reading N-1.
                            acc_next   = sum_sat;
                            ovf_next   = ovf_reg | sat;
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        acc_out_next   = acc_reg;
                        ovf_out_next   = ovf_reg;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        cnt_next       = '0;
                        ovf_next       = 1'b0;
                        state_next     = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign p_ready   = (state_reg != HOLD);
    assign p_drop    = p_drop_reg;
    assign out_valid = out_valid_reg;
    assign acc_out   = acc_out_reg;
    assign ovf_out   = ovf_out_reg;
    assign grp_cnt   = cnt_reg;

endmodule

// File: tb/tb_mul_acc_buf.sv
// Bench for mul_acc_buf: three instances (default, AW=17, N=1) share stimulus;
// directed scenarios plus random traffic against a group-sum reference model.
module tb_mul_acc_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        p_valid;
    logic [15:0] p;
    logic        out_ready;

    logic        p_ready_a, p_drop_a, out_valid_a, ovf_a;
    logic [19:0] acc_a;
    logic [7:0]  grp_a;
    logic        p_ready_b, p_drop_b, out_valid_b, ovf_b;
    logic [16:0] acc_b;
    logic [7:0]  grp_b;
    logic        p_ready_c, p_drop_c, out_valid_c, ovf_c;
    logic [19:0] acc_c;
    logic [7:0]  grp_c;

    logic        rdy_o [3];
    logic        drop_o[3];
    logic        ov_o  [3];
    logic        ovf_o [3];
    logic [19:0] acc_o [3];
    logic [7:0]  grp_o [3];

    int checks = 0;
    int errors = 0;

    localparam int NN [3] = '{4, 4, 1};
    localparam int AWS[3] = '{20, 17, 20};

    // Reference state: true (unsaturated) running sum and product count per group.
    longint m_sum [3];
    int     m_n   [3];
    bit     m_park[3];
    bit     m_ov  [3];
    longint m_acc [3];
    bit     m_ovf [3];
    bit     m_drop[3];

    always #5 clk = ~clk;

    mul_acc_buf u_dut (
        .clk(clk), .reset(reset), .clr(clr), .p_valid(p_valid), .p(p),
        .p_ready(p_ready_a), .p_drop(p_drop_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .acc_out(acc_a), .ovf_out(ovf_a), .grp_cnt(grp_a)
    );

    mul_acc_buf #(.AW(17)) u_sat (
        .clk(clk), .reset(reset), .clr(clr), .p_valid(p_valid), .p(p),
        .p_ready(p_ready_b), .p_drop(p_drop_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .acc_out(acc_b), .ovf_out(ovf_b), .grp_cnt(grp_b)
    );

    mul_acc_buf #(.N(1)) u_n1 (
        .clk(clk), .reset(reset), .clr(clr), .p_valid(p_valid), .p(p),
        .p_ready(p_ready_c), .p_drop(p_drop_c), .out_valid(out_valid_c),
        .out_ready(out_ready), .acc_out(acc_c), .ovf_out(ovf_c), .grp_cnt(grp_c)
    );

    assign rdy_o[0] = p_ready_a;  assign rdy_o[1] = p_ready_b;  assign rdy_o[2] = p_ready_c;
    assign drop_o[0] = p_drop_a;  assign drop_o[1] = p_drop_b;  assign drop_o[2] = p_drop_c;
    assign ov_o[0] = out_valid_a; assign ov_o[1] = out_valid_b; assign ov_o[2] = out_valid_c;
    assign ovf_o[0] = ovf_a;      assign ovf_o[1] = ovf_b;      assign ovf_o[2] = ovf_c;
    assign acc_o[0] = acc_a;      assign acc_o[1] = {3'b000, acc_b}; assign acc_o[2] = acc_c;
    assign grp_o[0] = grp_a;      assign grp_o[1] = grp_b;      assign grp_o[2] = grp_c;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_sum[i] = 0; m_n[i] = 0; m_park[i] = 0; m_ov[i] = 0;
            m_acc[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit     slot;
            bit     load;
            longint maxv;
            maxv = (64'd1 << AWS[i]) - 1;
            slot = !m_ov[i] || out_ready;
            load = 0;
            m_drop[i] = m_park[i] && p_valid;
            if (clr) begin
                m_sum[i] = 0; m_n[i] = 0; m_park[i] = 0;
            end else if (m_park[i]) begin
                load = slot;
            end else if (p_valid) begin
                m_sum[i] += longint'(p);
                m_n[i]++;
                if (m_n[i] == NN[i]) begin
                    if (slot) load = 1;
                    else m_park[i] = 1;
                end
            end
            if (load) begin
                m_ov[i]  = 1;
                m_acc[i] = (m_sum[i] > maxv) ? maxv : m_sum[i];
                m_ovf[i] = (m_sum[i] > maxv);
                m_sum[i] = 0; m_n[i] = 0; m_park[i] = 0;
            end else if (out_ready) begin
                m_ov[i] = 0;
            end
        end
    endtask

    task automatic drive(input bit c, input bit v, input logic [15:0] pp, input bit r);
        clr = c; p_valid = v; p = pp; out_ready = r;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] pp, input bit r);
        drive(1'b0, 1'b1, pp, r);
        tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 1'b0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid_a); end
        checks++; if (acc_a !== 20'd0) begin errors++; $display("FAIL reset_acc got %0h want 0", acc_a); end
        checks++; if (ovf_a !== 1'b0 || p_drop_a !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%0b drop=%0b want 0 0", ovf_a, p_drop_a); end
        checks++; if (grp_a !== 8'd0 || p_ready_a !== 1'b1) begin errors++; $display("FAIL reset_cnt_rdy got cnt=%0d rdy=%0b want 0 1", grp_a, p_ready_a); end
        $display("reset: valid=%0b acc=%0h cnt=%0d", out_valid_a, acc_a, grp_a);
    endtask

    task automatic test_basic();
        apply_reset();
        push(16'd100, 1'b1);
        push(16'd200, 1'b1);
        checks++; if (grp_a !== 8'd2) begin errors++; $display("FAIL basic_midcnt got %0d want 2", grp_a); end
        push(16'd300, 1'b1);
        push(16'd400, 1'b1);
        checks++; if (out_valid_a !== 1'b1 || acc_a !== 20'd1000) begin errors++; $display("FAIL basic_result got v=%0b acc=%0d want 1 1000", out_valid_a, acc_a); end
        checks++; if (ovf_a !== 1'b0 || grp_a !== 8'd0) begin errors++; $display("FAIL basic_flags got ovf=%0b cnt=%0d want 0 0", ovf_a, grp_a); end
        $display("basic: group result acc=%0d", acc_a);
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        tick();
        checks++; if (out_valid_a !== 1'b0 || acc_a !== 20'd1000) begin errors++; $display("FAIL basic_consume got v=%0b acc=%0d want 0 1000", out_valid_a, acc_a); end
    endtask

    task automatic test_saturation();
        apply_reset();
        repeat (4) push(16'hFFFF, 1'b1);
        checks++; if (acc_b !== 17'h1FFFF || ovf_b !== 1'b1) begin errors++; $display("FAIL sat_result got acc=%0h ovf=%0b want 1ffff 1", acc_b, ovf_b); end
        checks++; if (acc_a !== 20'h3FFFC || ovf_a !== 1'b0) begin errors++; $display("FAIL sat_wide got acc=%0h ovf=%0b want 3fffc 0", acc_a, ovf_a); end
        $display("saturation: aw17 acc=%0h ovf=%0b", acc_b, ovf_b);
        repeat (4) push(16'd1, 1'b1);
        checks++; if (acc_b !== 17'd4 || ovf_b !== 1'b0 || out_valid_b !== 1'b1) begin errors++; $display("FAIL sat_next got acc=%0h ovf=%0b v=%0b want 4 0 1", acc_b, ovf_b, out_valid_b); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        repeat (4) push(16'd10, 1'b0);
        checks++; if (out_valid_a !== 1'b1 || acc_a !== 20'd40) begin errors++; $display("FAIL bp_first got v=%0b acc=%0d want 1 40", out_valid_a, acc_a); end
        repeat (4) push(16'd10, 1'b0);
        checks++; if (p_ready_a !== 1'b0 || grp_a !== 8'd3) begin errors++; $display("FAIL bp_hold got rdy=%0b cnt=%0d want 0 3", p_ready_a, grp_a); end
        push(16'd10, 1'b0);
        checks++; if (p_drop_a !== 1'b1) begin errors++; $display("FAIL bp_drop got %0b want 1", p_drop_a); end
        drive(1'b0, 1'b0, 16'd0, 1'b0);
        tick();
        checks++; if (p_drop_a !== 1'b0) begin errors++; $display("FAIL bp_drop_pulse got %0b want 0", p_drop_a); end
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        tick();
        checks++; if (out_valid_a !== 1'b1 || acc_a !== 20'd40 || p_ready_a !== 1'b1 || grp_a !== 8'd0) begin errors++; $display("FAIL bp_release got v=%0b acc=%0d rdy=%0b cnt=%0d want 1 40 1 0", out_valid_a, acc_a, p_ready_a, grp_a); end
        $display("backpressure: parked group released acc=%0d", acc_a);
        tick();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", out_valid_a); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        push(16'd5, 1'b1);
        push(16'd6, 1'b1);
        drive(1'b1, 1'b1, 16'd55, 1'b1);
        tick();
        checks++; if (grp_a !== 8'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", grp_a); end
        push(16'd1, 1'b1); push(16'd2, 1'b1); push(16'd3, 1'b1); push(16'd4, 1'b1);
        checks++; if (acc_a !== 20'd10 || out_valid_a !== 1'b1) begin errors++; $display("FAIL clr_sum got acc=%0d v=%0b want 10 1", acc_a, out_valid_a); end
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        tick();
        repeat (4) push(16'd2, 1'b0);
        repeat (3) push(16'd3, 1'b0);
        push(16'd3, 1'b1);
        checks++; if (out_valid_a !== 1'b1 || acc_a !== 20'd12) begin errors++; $display("FAIL handoff_reload got v=%0b acc=%0d want 1 12", out_valid_a, acc_a); end
        $display("simultaneous: handoff+reload acc=%0d", acc_a);
        repeat (4) push(16'd5, 1'b0);
        checks++; if (p_ready_a !== 1'b0) begin errors++; $display("FAIL clr_hold_pre got rdy=%0b want 0", p_ready_a); end
        drive(1'b1, 1'b0, 16'd0, 1'b0);
        tick();
        checks++; if (p_ready_a !== 1'b1 || grp_a !== 8'd0 || out_valid_a !== 1'b1 || acc_a !== 20'd12) begin errors++; $display("FAIL clr_hold got rdy=%0b cnt=%0d v=%0b acc=%0d want 1 0 1 12", p_ready_a, grp_a, out_valid_a, acc_a); end
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        tick();
        checks++; if (out_valid_a !== 1'b0 || acc_a !== 20'd12) begin errors++; $display("FAIL clr_hold_drain got v=%0b acc=%0d want 0 12", out_valid_a, acc_a); end
    endtask

    task automatic test_reset_mid_group();
        apply_reset();
        push(16'd1, 1'b0); push(16'd2, 1'b0); push(16'd3, 1'b0); push(16'd4, 1'b0);
        push(16'd100, 1'b0); push(16'd100, 1'b0);
        checks++; if (out_valid_a !== 1'b1 || acc_a !== 20'd10 || grp_a !== 8'd2) begin errors++; $display("FAIL midrst_pre got v=%0b acc=%0d cnt=%0d want 1 10 2", out_valid_a, acc_a, grp_a); end
        #3 reset = 1'b1;
        #1;
        checks++; if (out_valid_a !== 1'b0 || acc_a !== 20'd0 || grp_a !== 8'd0 || ovf_a !== 1'b0) begin errors++; $display("FAIL midrst_async got v=%0b acc=%0d cnt=%0d ovf=%0b want 0 0 0 0", out_valid_a, acc_a, grp_a, ovf_a); end
        model_clear();
        drive(1'b0, 1'b0, 16'd0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        push(16'd1, 1'b1); push(16'd2, 1'b1); push(16'd3, 1'b1); push(16'd4, 1'b1);
        checks++; if (out_valid_a !== 1'b1 || acc_a !== 20'd10) begin errors++; $display("FAIL midrst_after got v=%0b acc=%0d want 1 10", out_valid_a, acc_a); end
        $display("reset mid-group: following group acc=%0d", acc_a);
    endtask

    task automatic test_n1();
        apply_reset();
        push(16'hABCD, 1'b1);
        checks++; if (out_valid_c !== 1'b1 || acc_c !== 20'h0ABCD) begin errors++; $display("FAIL n1_first got v=%0b acc=%0h want 1 0abcd", out_valid_c, acc_c); end
        push(16'h0001, 1'b1);
        checks++; if (out_valid_c !== 1'b1 || acc_c !== 20'h00001 || grp_c !== 8'd0) begin errors++; $display("FAIL n1_second got v=%0b acc=%0h cnt=%0d want 1 1 0", out_valid_c, acc_c, grp_c); end
        $display("n1: results 0abcd then %0h", acc_c);
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [15:0] pp;
            bit          seen;
            pp = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
            drive($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, pp, $urandom_range(0, 9) < 6);
            seen = out_valid_a && out_ready;
            if (seen) $display("xfer: cycle %0d acc=%0h ovf=%0b", cyc, acc_a, ovf_a);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++; if (ov_o[i] !== m_ov[i]) begin errors++; $display("FAIL rnd_valid inst %0d cyc %0d got %0b want %0b", i, cyc, ov_o[i], m_ov[i]); end
                checks++; if (acc_o[i] !== 20'(m_acc[i])) begin errors++; $display("FAIL rnd_acc inst %0d cyc %0d got %0h want %0h", i, cyc, acc_o[i], m_acc[i]); end
                checks++; if (ovf_o[i] !== m_ovf[i]) begin errors++; $display("FAIL rnd_ovf inst %0d cyc %0d got %0b want %0b", i, cyc, ovf_o[i], m_ovf[i]); end
                checks++; if (grp_o[i] !== 8'(m_park[i] ? NN[i] - 1 : m_n[i])) begin errors++; $display("FAIL rnd_cnt inst %0d cyc %0d got %0d want %0d", i, cyc, grp_o[i], m_park[i] ? NN[i] - 1 : m_n[i]); end
                checks++; if (rdy_o[i] !== !m_park[i]) begin errors++; $display("FAIL rnd_ready inst %0d cyc %0d got %0b want %0b", i, cyc, rdy_o[i], !m_park[i]); end
                checks++; if (drop_o[i] !== m_drop[i]) begin errors++; $display("FAIL rnd_drop inst %0d cyc %0d got %0b want %0b", i, cyc, drop_o[i], m_drop[i]); end
            end
        end
        drive(1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_group();
        test_n1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
